// File: rtl/adc_jesd204_cpack.sv
// adc_jesd204_cpack: compacts enabled ADC channel samples into full-width words,
// buffered in a 2-entry FIFO with overflow reporting on adc_dovf.
module adc_jesd204_cpack #(
   parameter int NUM_CHANNELS        = 4,
   parameter int SAMPLES_PER_CHANNEL = 2,
   parameter int SAMPLE_WIDTH        = 16
) (
   input  logic                                                    adc_clk,
   input  logic                                                    adc_rstn,
   input  logic [NUM_CHANNELS-1:0]                                 adc_enable,
   input  logic [NUM_CHANNELS-1:0]                                 adc_valid,
   input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] adc_data,
   output logic                                                    pack_valid,
   input  logic                                                    pack_ready,
   output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] pack_data,
   output logic                                                    adc_dovf
);
   localparam int N  = NUM_CHANNELS;
   localparam int S  = SAMPLES_PER_CHANNEL;
   localparam int SW = SAMPLE_WIDTH;
   localparam int W  = N * S;
   localparam int FW = $clog2(2 * W) + 1;
   localparam int KW = $clog2(W);

   logic [N-1:0]    en_q;
   logic [FW-1:0]   fill_q, fill_d, beat_n, total;
   logic [SW-1:0]   acc_q [2*W];
   logic [SW-1:0]   acc_d [2*W];
   logic [SW-1:0]   merged [2*W];
   logic [SW-1:0]   beat_s [W];
   logic [W*SW-1:0] mem_q [2];
   logic [W*SW-1:0] word_data;
   logic [1:0]      cnt_q, cnt_d;
   logic            wr_q, rd_q, dovf_q;
   logic            en_chg, in_beat, word, pop, push;

   assign en_chg  = adc_enable != en_q;
   assign in_beat = |(adc_valid & adc_enable) && !en_chg;

   // Gather enabled samples in sample-interleaved order
   always_comb begin
      int k;
      k = 0;
      for (int i = 0; i < W; i++) beat_s[i] = '0;
      for (int s = 0; s < S; s++)
         for (int c = 0; c < N; c++)
            if (adc_enable[c]) begin
               beat_s[KW'(k)] = adc_data[(c*S+s)*SW +: SW];
               k = k + 1;
            end
      beat_n = FW'(k);
   end

   assign total = fill_q + beat_n;
   assign word  = in_beat && total >= FW'(W);

   always_comb begin
      for (int i = 0; i < 2*W; i++) begin
         merged[i] = acc_q[i];
         if (in_beat && i >= int'(fill_q) && i < int'(total))
            merged[i] = beat_s[KW'(i - int'(fill_q))];
      end
      for (int i = 0; i < W; i++) begin
         acc_d[i]   = word ? merged[i+W] : merged[i];
         acc_d[i+W] = word ? '0 : merged[i+W];
      end
      for (int i = 0; i < W; i++) word_data[i*SW +: SW] = merged[i];
   end

   assign fill_d = en_chg ? '0 : !in_beat ? fill_q : word ? total - FW'(W) : total;

   // A full FIFO still accepts a word when the head leaves in the same cycle
   assign pop        = pack_valid && pack_ready;
   assign push       = word && (cnt_q != 2'd2 || pop);
   assign cnt_d      = cnt_q + 2'(push) - 2'(pop);
   assign pack_valid = cnt_q != 2'd0;
   assign pack_data  = mem_q[rd_q];
   assign adc_dovf   = dovf_q;

   always_ff @(posedge adc_clk) begin
      if (!adc_rstn) begin
         en_q   <= '0;
         fill_q <= '0;
         acc_q  <= '{default: '0};
         mem_q  <= '{default: '0};
         cnt_q  <= '0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         dovf_q <= 1'b0;
      end else begin
         en_q   <= adc_enable;
         fill_q <= fill_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         wr_q   <= wr_q ^ push;
         rd_q   <= rd_q ^ pop;
         dovf_q <= word && !push;
         if (push) mem_q[wr_q] <= word_data;
      end
   end
endmodule

// File: tb/tb_adc_jesd204_cpack.sv
// tb_adc_jesd204_cpack: queue-based sample/FIFO model checked every cycle,
// plus directed scenarios with literal expected words.
module tb_adc_jesd204_cpack;
   localparam int N  = 4;
   localparam int S  = 2;
   localparam int SW = 16;
   localparam int W  = N * S;

   logic            clk = 1'b0, rstn = 1'b0, rdy = 1'b0;
   logic [N-1:0]    en = '0, vld = '0;
   logic [W*SW-1:0] din = '0;
   logic            pack_valid, adc_dovf;
   logic [W*SW-1:0] pack_data;

   int n_cmp = 0, n_bad = 0;
   bit run = 1'b0;

   adc_jesd204_cpack #(.NUM_CHANNELS(N), .SAMPLES_PER_CHANNEL(S), .SAMPLE_WIDTH(SW)) dut (
      .adc_clk(clk), .adc_rstn(rstn), .adc_enable(en), .adc_valid(vld), .adc_data(din),
      .pack_valid(pack_valid), .pack_ready(rdy), .pack_data(pack_data), .adc_dovf(adc_dovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W*SW-1:0] got, input logic [W*SW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [W*SW-1:0] mk(input logic [15:0] base);
      logic [W*SW-1:0] r;
      for (int c = 0; c < N; c++)
         for (int s = 0; s < S; s++)
            r[(c*S+s)*SW +: SW] = base + 16'(c*16 + s);
      return r;
   endfunction

   function automatic logic [W*SW-1:0] wd(input logic [15:0] k0, k1, k2, k3, k4, k5, k6, k7);
      return {k7, k6, k5, k4, k3, k2, k1, k0};
   endfunction

   // Model: pending samples as a flat queue, output FIFO as a queue of words
   logic [SW-1:0]   mq[$];
   logic [W*SW-1:0] mf[$];
   logic [N-1:0]    men;
   logic [W*SW-1:0] mw;
   bit              mdovf, mpop, mdone;

   always @(posedge clk) begin
      if (!rstn) begin
         mq.delete();
         mf.delete();
         men   = '0;
         mdovf = 1'b0;
      end else begin
         mpop  = mf.size() > 0 && rdy;
         mdone = 1'b0;
         mdovf = 1'b0;
         if (en != men) mq.delete();
         else if ((vld & en) != '0) begin
            for (int s = 0; s < S; s++)
               for (int c = 0; c < N; c++)
                  if (en[c]) mq.push_back(din[(c*S+s)*SW +: SW]);
            if (mq.size() >= W) begin
               for (int k = 0; k < W; k++) mw[k*SW +: SW] = mq.pop_front();
               mdone = 1'b1;
            end
         end
         men = en;
         if (mpop) void'(mf.pop_front());
         if (mdone) begin
            if (mf.size() < 2) mf.push_back(mw);
            else mdovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check("model_valid", 128'(pack_valid), 128'(mf.size() > 0));
         if (mf.size() > 0) check("model_data", pack_data, mf[0]);
         check("model_dovf", 128'(adc_dovf), 128'(mdovf));
      end
   end

   task automatic beat(input logic [N-1:0] m, input logic [15:0] base, input logic r);
      en = m; vld = m; din = mk(base); rdy = r;
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      vld = '0; rdy = r;
      @(negedge clk);
   endtask

   task automatic setmask(input logic [N-1:0] m);
      en = m; vld = '0; rdy = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", 128'(pack_valid), 128'(0));
      check("rst_data", pack_data, 128'(0));
      check("rst_dovf", 128'(adc_dovf), 128'(0));
      rstn = 1'b1;
      run  = 1'b1;

      setmask(4'hf);
      beat(4'hf, 16'h0000, 1'b1);
      check("t1_valid", 128'(pack_valid), 128'(1));
      check("t1_data", pack_data, wd(16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0001, 16'h0011, 16'h0021, 16'h0031));
      idle(1'b1);

      setmask(4'h1);
      for (int b = 0; b < 4; b++) begin
         beat(4'h1, 16'(b << 8), 1'b1);
         if (b < 3) check("t2_nowrd", 128'(pack_valid), 128'(0));
      end
      check("t2_valid", 128'(pack_valid), 128'(1));
      check("t2_data", pack_data, wd(16'h0000, 16'h0001, 16'h0100, 16'h0101, 16'h0200, 16'h0201, 16'h0300, 16'h0301));
      idle(1'b1);

      setmask(4'h7);
      beat(4'h7, 16'h0000, 1'b1);
      check("t3_nowrd", 128'(pack_valid), 128'(0));
      beat(4'h7, 16'h0000, 1'b1);
      check("t3_data1", pack_data, wd(16'h0000, 16'h0010, 16'h0020, 16'h0001, 16'h0011, 16'h0021, 16'h0000, 16'h0010));
      beat(4'h7, 16'h0000, 1'b1);
      beat(4'h7, 16'h0000, 1'b1);
      check("t3_valid3", 128'(pack_valid), 128'(1));
      check("t3_data3", pack_data, wd(16'h0011, 16'h0021, 16'h0000, 16'h0010, 16'h0020, 16'h0001, 16'h0011, 16'h0021));
      idle(1'b1);
      idle(1'b1);

      setmask(4'hf);
      beat(4'hf, 16'h0000, 1'b0);
      beat(4'hf, 16'h0100, 1'b0);
      check("t4_nodovf", 128'(adc_dovf), 128'(0));
      beat(4'hf, 16'h0200, 1'b0);
      check("t4_dovf", 128'(adc_dovf), 128'(1));
      idle(1'b0);
      check("t4_dovf_end", 128'(adc_dovf), 128'(0));
      check("t4_word1", pack_data, wd(16'h0000, 16'h0010, 16'h0020, 16'h0030, 16'h0001, 16'h0011, 16'h0021, 16'h0031));
      idle(1'b1);
      check("t4_word2", pack_data, wd(16'h0100, 16'h0110, 16'h0120, 16'h0130, 16'h0101, 16'h0111, 16'h0121, 16'h0131));
      idle(1'b1);
      check("t4_empty", 128'(pack_valid), 128'(0));

      setmask(4'h1);
      beat(4'h1, 16'h0000, 1'b1);
      beat(4'h1, 16'h0100, 1'b1);
      beat(4'h3, 16'h0200, 1'b1);
      check("t5_flush", 128'(pack_valid), 128'(0));
      beat(4'h3, 16'h0300, 1'b1);
      check("t5_nowrd", 128'(pack_valid), 128'(0));
      beat(4'h3, 16'h0400, 1'b1);
      check("t5_valid", 128'(pack_valid), 128'(1));
      check("t5_data", pack_data, wd(16'h0300, 16'h0310, 16'h0301, 16'h0311, 16'h0400, 16'h0410, 16'h0401, 16'h0411));
      idle(1'b1);

      setmask(4'h1);
      for (int b = 0; b < 4; b++) beat(4'h1, 16'(b << 8), 1'b0);
      check("t6_pre", 128'(pack_valid), 128'(1));
      beat(4'h1, 16'h0500, 1'b0);
      beat(4'h1, 16'h0600, 1'b0);
      rstn = 1'b0;
      idle(1'b0);
      rstn = 1'b1;
      check("t6_valid", 128'(pack_valid), 128'(0));
      check("t6_data", pack_data, 128'(0));
      idle(1'b1);
      for (int b = 0; b < 4; b++) beat(4'h1, 16'h1000 + 16'(b << 8), 1'b1);
      check("t6_word", pack_data, wd(16'h1000, 16'h1001, 16'h1100, 16'h1101, 16'h1200, 16'h1201, 16'h1300, 16'h1301));
      idle(1'b1);
      idle(1'b1);
      check("t6_once", 128'(pack_valid), 128'(0));

      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
